// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the space-vector gate driver.
// Vector constants use gate bit order: bit0 = phase A, bit1 = B, bit2 = C.
package ac_motor_pkg;

  typedef enum logic [1:0] {
    LEG_IDLE = 2'd0,
    LEG_HI   = 2'd1,
    LEG_LO   = 2'd2,
    LEG_DEAD = 2'd3
  } leg_state_e;

  localparam logic [2:0] VEC_V1 = 3'b001;  // A
  localparam logic [2:0] VEC_V2 = 3'b011;  // A,B
  localparam logic [2:0] VEC_V3 = 3'b010;  // B
  localparam logic [2:0] VEC_V4 = 3'b110;  // B,C
  localparam logic [2:0] VEC_V5 = 3'b100;  // C
  localparam logic [2:0] VEC_V6 = 3'b101;  // A,C

  localparam logic [2:0] SECTOR_MIN = 3'd1;
  localparam logic [2:0] SECTOR_MAX = 3'd6;

  function automatic logic [2:0] sector_vec(input logic [2:0] sector);
    case (sector)
      3'd1:    return VEC_V1;
      3'd2:    return VEC_V2;
      3'd3:    return VEC_V3;
      3'd4:    return VEC_V4;
      3'd5:    return VEC_V5;
      3'd6:    return VEC_V6;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] next_sector(input logic [2:0] sector);
    return (sector == SECTOR_MAX) ? SECTOR_MIN : sector + 3'd1;
  endfunction

endpackage

// File: rtl/ac_motor_dead_time_leg.sv
// One inverter leg: complementary switch FSM with dead-time down-counter.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   S_IDLE    | both switches off, no target yet (reset/fault)
//   S_HI      | high-side switch on
//   S_LO      | low-side switch on
//   S_DEAD    | both off, counting down before entering target
module ac_motor_dead_time_leg
  import ac_motor_pkg::*;
#(
  parameter int DEAD_TIME = 100,
  parameter int CNT_W     = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       force_idle,
  input  logic [1:0] desired,
  output logic       gate_hi,
  output logic       gate_lo
);

  localparam logic [1:0] S_IDLE = LEG_IDLE;
  localparam logic [1:0] S_HI   = LEG_HI;
  localparam logic [1:0] S_LO   = LEG_LO;
  localparam logic [1:0] S_DEAD = LEG_DEAD;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_TIME - 1);

  logic [1:0]       st, st_nxt;
  logic [1:0]       tgt, tgt_nxt;  // target the running dead-time count belongs to
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Next-state: any change of target restarts the dead-time window.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    tgt_nxt = tgt;
    if (force_idle) begin
      st_nxt  = S_IDLE;
      cnt_nxt = '0;
      tgt_nxt = S_IDLE;
    end else begin
      case (st)
        S_IDLE: begin
          if (desired == S_HI || desired == S_LO) begin
            st_nxt  = S_DEAD;
            cnt_nxt = CNT_LOAD;
            tgt_nxt = desired;
          end
        end
        S_HI: begin
          if (desired == S_LO) begin
            st_nxt  = S_DEAD;
            cnt_nxt = CNT_LOAD;
            tgt_nxt = desired;
          end
        end
        S_LO: begin
          if (desired == S_HI) begin
            st_nxt  = S_DEAD;
            cnt_nxt = CNT_LOAD;
            tgt_nxt = desired;
          end
        end
        default: begin
          if (desired != tgt) begin
            cnt_nxt = CNT_LOAD;
            tgt_nxt = desired;
          end else if (cnt == '0) begin
            st_nxt = desired;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // State, counter and registered gate enables decoded from the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st      <= S_IDLE;
      tgt     <= S_IDLE;
      cnt     <= '0;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
    end else begin
      st      <= st_nxt;
      tgt     <= tgt_nxt;
      cnt     <= cnt_nxt;
      gate_hi <= (st_nxt == S_HI);
      gate_lo <= (st_nxt == S_LO);
    end
  end

endmodule

// File: rtl/ac_motor_vector_gate_driver.sv
// Space-vector gate driver: registers sector/vector select, decodes the
// desired switching vector, detects illegal selects and drives three legs.
module ac_motor_vector_gate_driver
  import ac_motor_pkg::*;
#(
  parameter int DEAD_TIME = 100,
  parameter int CNT_W     = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] SECTOR,
  input  logic       U_0,
  input  logic       U_1,
  input  logic       U_2,
  input  logic       U_7,
  output logic [2:0] GATE_HI,
  output logic [2:0] GATE_LO,
  output logic       FAULT
);

  logic [2:0] sector_q;
  logic [3:0] sel_q;     // {U_7, U_2, U_1, U_0}
  logic       des_valid;
  logic [2:0] des_vec;
  logic       sector_bad, multi_sel, fault_det, force_idle;
  logic [2:0] sel_vec;
  logic [1:0] leg_des [3];

  // Decode the registered select into a vector and flag illegal combinations.
  always_comb begin
    sector_bad = (sector_q < SECTOR_MIN) || (sector_q > SECTOR_MAX);
    multi_sel  = (sel_q & (sel_q - 4'd1)) != 4'd0;
    fault_det  = multi_sel || ((sel_q[1] || sel_q[2]) && sector_bad);
    if (sel_q[3])      sel_vec = 3'b111;
    else if (sel_q[2]) sel_vec = sector_vec(next_sector(sector_q));
    else if (sel_q[1]) sel_vec = sector_vec(sector_q);
    else               sel_vec = 3'b000;
  end

  // Idle the legs in the same cycle the fault flag rises, so gates are never
  // on while FAULT reads 1.
  assign force_idle = FAULT || fault_det;

  // Input sampling, sticky fault and the held desired vector.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sector_q  <= 3'd0;
      sel_q     <= 4'd0;
      des_valid <= 1'b0;
      des_vec   <= 3'b000;
      FAULT     <= 1'b0;
    end else begin
      sector_q <= SECTOR;
      sel_q    <= {U_7, U_2, U_1, U_0};
      FAULT    <= FAULT || fault_det;
      if (!FAULT && !fault_det && sel_q != 4'd0) begin
        des_valid <= 1'b1;
        des_vec   <= sel_vec;
      end
    end
  end

  // Per-leg target: nothing until the first valid vector, then HI/LO per bit.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (!des_valid)     leg_des[i] = LEG_IDLE;
      else if (des_vec[i]) leg_des[i] = LEG_HI;
      else                 leg_des[i] = LEG_LO;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_leg
    ac_motor_dead_time_leg #(
      .DEAD_TIME(DEAD_TIME),
      .CNT_W    (CNT_W)
    ) u_leg (
      .CLK       (CLK),
      .RESET     (RESET),
      .force_idle(force_idle),
      .desired   (leg_des[gi]),
      .gate_hi   (GATE_HI[gi]),
      .gate_lo   (GATE_LO[gi])
    );
  end

endmodule
